// File: rtl/shift_arb.sv
// shift_arb: two requesters (0 = EX pipe, 1 = multicycle/CSR path) share one
// shifter. Round-robin grant, registered operands, one-cycle result latency,
// back-to-back accept when the current result is taken in the same cycle.
//
// Ports:
//   clk, rst            core clock, async active-high reset
//   flush               drop any in-flight op, block accepts this cycle
//   req_valid/req_ready per-requester request handshake (bit i = requester i)
//   req_op*/w*/num*/cnt* per-requester op fields ({sra,srl,sll} one-hot)
//   resp_valid/ready    per-requester result handshake (one-hot on owner)
//   resp_data           shared result bus, qualified by resp_valid
//   busy                an op is held (RESP state)

// Shift datapath. W ops mask the count to 5 bits and shift the low word;
// the caller sign-extends the low 32 bits of the result.
module alu_shift #(
  parameter int XLEN = 64
) (
  input  logic [2:0]      op,
  input  logic            w,
  input  logic [XLEN-1:0] num,
  input  logic [5:0]      cnt,
  output logic [XLEN-1:0] out
);
  logic [5:0]      sh;
  logic [XLEN-1:0] srl_src, sra_src;

  always_comb begin
    sh      = w ? {1'b0, cnt[4:0]} : cnt;
    // right shifts of a W op must pull in zeros / bit 31, not the upper word
    srl_src = w ? {32'b0, num[31:0]} : num;
    sra_src = w ? {{32{num[31]}}, num[31:0]} : num;
    out     = '0;
    case (op)
      3'b001:  out = num << sh;
      3'b010:  out = srl_src >> sh;
      3'b100:  out = $signed(sra_src) >>> sh;
      default: out = '0;
    endcase
  end
endmodule

module shift_arb #(
  parameter int XLEN = 64
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic [1:0]      req_valid,
  output logic [1:0]      req_ready,
  input  logic [2:0]      req_op0,
  input  logic [2:0]      req_op1,
  input  logic            req_w0,
  input  logic            req_w1,
  input  logic [XLEN-1:0] req_num0,
  input  logic [XLEN-1:0] req_num1,
  input  logic [5:0]      req_cnt0,
  input  logic [5:0]      req_cnt1,
  output logic [1:0]      resp_valid,
  input  logic [1:0]      resp_ready,
  output logic [XLEN-1:0] resp_data,
  output logic            busy
);
  typedef enum logic {IDLE = 1'b0, RESP = 1'b1} state_t;

  state_t          state, state_d;
  logic            owner, rr_prio;
  logic [2:0]      op_q;
  logic            w_q;
  logic [XLEN-1:0] num_q, sh_out;
  logic [5:0]      cnt_q;

  logic            win, accept, sel, resp_hs;
  logic [1:0]      gnt;

  // current result leaves this cycle
  assign resp_hs = (state == RESP) && resp_ready[owner];

  always_comb begin
    win    = (state == IDLE) || resp_hs;
    gnt[0] = req_valid[0] && (!req_valid[1] || !rr_prio);
    gnt[1] = req_valid[1] && (!req_valid[0] ||  rr_prio);
    req_ready = (win && !flush) ? gnt : 2'b00;
    accept = |(req_valid & req_ready);
    sel    = req_ready[1];
  end

  always_comb begin
    state_d = state;
    if (flush)                 state_d = IDLE;
    else if (accept)           state_d = RESP;
    else if (resp_hs)          state_d = IDLE;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      owner   <= 1'b0;
      rr_prio <= 1'b0;
      op_q    <= '0;
      w_q     <= 1'b0;
      num_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state <= state_d;
      if (accept) begin
        owner   <= sel;
        rr_prio <= ~sel;
        op_q    <= sel ? req_op1  : req_op0;
        w_q     <= sel ? req_w1   : req_w0;
        num_q   <= sel ? req_num1 : req_num0;
        cnt_q   <= sel ? req_cnt1 : req_cnt0;
      end
    end
  end

  alu_shift #(.XLEN(XLEN)) u_shift (
    .op  (op_q),
    .w   (w_q),
    .num (num_q),
    .cnt (cnt_q),
    .out (sh_out)
  );

  // operands clear on reset with op_q = 000, so resp_data reads 0 then too
  assign resp_data  = w_q ? {{(XLEN-32){sh_out[31]}}, sh_out[31:0]} : sh_out;
  assign resp_valid = (state == RESP) ? (owner ? 2'b10 : 2'b01) : 2'b00;
  assign busy       = (state == RESP);
endmodule

// File: doc/shift_arb.md
Name: shift_arb

Overview:
- Shares one instance of the core's shift datapath (alu_shift) between two requesters.
  - Requester 0: the integer EX pipe.
  - Requester 1: the multicycle/CSR side path.
- Round-robin arbitration with valid/ready handshakes on both the request and response sides.
- Operands are registered and the selected requester receives a registered result, including RV64 *W-form sign extension.
- Sits in EX between issue and the writeback muxes.

Parameters:
- XLEN, 64, datapath width. Only 64 is supported; shift count stays 6 bits.

Ports:
- clk  in  1  core clock.
- rst  in  1  reset: asynchronous, active-high.
- flush  in  1  kills any in-flight op; its response is dropped.
- req_valid  in  2  per-requester request valid, bit i = requester i.
- req_ready  out  2  per-requester grant/accept.
- req_op0 / req_op1  in  3  one-hot op {sra, srl, sll}: 100 = sra, 010 = srl, 001 = sll.
- req_w0 / req_w1  in  1  32-bit (*W) operation.
- req_num0 / req_num1  in  XLEN  operand to shift.
- req_cnt0 / req_cnt1  in  6  shift count.
- resp_valid  out  2  result valid, bit i = owner.
- resp_ready  in  2  per-requester result accept.
- resp_data  out  XLEN  result, common to both requesters; qualified by resp_valid.
- busy  out  1  an op is held (the RESP state).

Behaviour:
- FSM states: IDLE, RESP. Registers:
  - owner (1 bit).
  - rr_prio (1 bit; 0 means requester 0 wins ties).
  - op_q, w_q, num_q, cnt_q.
- Reset (async): state = IDLE, rr_prio = 0, owner = 0, operand registers = 0.
  - Outputs at reset: req_ready = 00, resp_valid = 00, busy = 0, resp_data = 0.
- Acceptance window: a new request may be accepted when
  - state = IDLE, or
  - state = RESP and resp_valid[owner] & resp_ready[owner] in the same cycle (back-to-back).
- Arbitration (combinational, within the window, flush = 0):
  - Only one valid: it wins.
  - Both valid: the requester indicated by rr_prio wins.
  - req_ready is one-hot on the winner only, and 00 outside the window. Ready depends on valid (allowed by the handshake contract).
- On accept (req_valid[i] & req_ready[i]):
  - Latch op/w/num/cnt of i and set owner = i.
  - Set rr_prio = ~i.
  - Next state = RESP.
- Latency: accept in cycle N → resp_valid[owner] = 1 from cycle N+1. Throughput is one op per cycle under back-to-back handshakes.
- In RESP:
  - resp_valid = one-hot(owner).
  - resp_data is computed combinationally from the registered operands through alu_shift; stable while held.
  - Handshake with no new accept → IDLE.
  - resp_ready low → hold; resp_data and owner do not change.
- Result rules:
  - w_q = 1: resp_data = sign-extension of shifter_out[31:0] to XLEN.
  - Otherwise resp_data = shifter_out.
  - Count is masked to 5 bits for W ops; this is done inside the shifter.
- Illegal op (op_q not one-hot, including 000): resp_data = 0, handshake unaffected.
- A requester must hold req_valid and its fields stable until accepted. Dropping valid before grant is allowed and does not change rr_prio.
- Flush:
  - Same cycle: req_ready = 00 and nothing is accepted.
  - Next edge: state = IDLE and resp_valid = 00.
  - rr_prio is not changed.
  - A response whose handshake completes in the flush cycle is still counted as delivered.
- busy = (state == RESP).
- Reset asserted mid-operation: immediate return to reset values with no response. Deassertion is synchronised externally.

Test Plan:
1. Single sll from requester 0, num = 0x1, cnt = 63, w = 0, resp_ready = 1:
   - ready0 in cycle N; resp_valid = 01 in N+1.
   - resp_data = 0x8000000000000000.
2. sraw from requester 1, num = 0xFFFFFFFF_80000000, cnt = 36 (masked to 4), w = 1:
   - resp_data = 0xFFFFFFFFF8000000; resp_valid = 10.
3. Both valid every cycle, resp_ready = 11:
   - Grants alternate 0,1,0,1 starting with 0 after reset, one result per cycle.
   - Results are routed to the matching resp_valid bit.
4. srl from requester 0, num = 0xF0, cnt = 4, resp_ready0 held low 3 cycles:
   - resp_data stays 0x0F and req_ready stays 00 during the stall.
   - The pending requester 1 is granted in the cycle resp_ready0 rises.
5. Accept a request, then flush in the next cycle with resp_ready = 0:
   - resp_valid drops to 00 after the edge and no response is delivered.
   - The next request is accepted from IDLE.
6. op = 011 (illegal), num = 0x1234:
   - resp_data = 0 with a normal handshake.
   - Async rst pulse mid-RESP clears resp_valid, busy and resp_data within the same cycle.
